// File: rtl/serpent_key_sched_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : serpent_key_sched_ctrl
// Purpose  : Sequences the shared Serpent key-schedule engine for the XTS
//            core. Arbitrates data-key (bank 0) and tweak-key (bank 1) load
//            requests round-robin, launches one schedule run at a time and
//            captures the 33 emitted 128-bit subkeys into the round-key RAM
//            at {bank, round}. Reports per-bank readiness and a sticky error
//            on timeout or short capture.
// Ports    : i_clk, i_rstn          - clock, async active-low reset
//            i_req_*/i_key_*/o_ack_* - requester handshakes (level req,
//                                      one-cycle ack, key sampled at ack)
//            o_ks_begin/o_ks_key     - engine start pulse and key
//            i_ks_subkey/address/valid - engine outputs
//            o_rk_we/addr/data       - round-key RAM write port
//            o_data_key_ready, o_tweak_key_ready, o_busy, o_error - status
// Revision : 1.0 - initial release
// ============================================================================
module serpent_key_sched_ctrl #(
    parameter int KS_TIMEOUT = 511
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_req_data,
    input  logic [255:0] i_key_data,
    output logic         o_ack_data,
    input  logic         i_req_tweak,
    input  logic [255:0] i_key_tweak,
    output logic         o_ack_tweak,
    output logic         o_ks_begin,
    output logic [255:0] o_ks_key,
    input  logic [127:0] i_ks_subkey,
    input  logic [5:0]   i_ks_address,
    input  logic         i_ks_subkey_valid,
    output logic         o_rk_we,
    output logic [6:0]   o_rk_addr,
    output logic [127:0] o_rk_data,
    output logic         o_data_key_ready,
    output logic         o_tweak_key_ready,
    output logic         o_busy,
    output logic         o_error
);

    localparam logic [9:0] c_TIMEOUT     = 10'(KS_TIMEOUT);
    localparam logic [5:0] c_NUM_SUBKEYS = 6'd33;
    localparam logic [5:0] c_LAST_ROUND  = 6'd32;
    localparam logic [5:0] c_ADDR_NONE   = 6'h3F;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_START   = 2'd1,
        ST_COLLECT = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t         state_q,      state_d;
    logic           last_grant_q, last_grant_d;  // 0 = data, 1 = tweak
    logic           bank_q,       bank_d;
    logic [255:0]   ks_key_q,     ks_key_d;
    logic [5:0]     prev_addr_q,  prev_addr_d;
    logic [5:0]     count_q,      count_d;
    logic [9:0]     timeout_q,    timeout_d;
    logic           seen_low_q,   seen_low_d;
    logic           rk_we_q,      rk_we_d;
    logic [6:0]     rk_addr_q,    rk_addr_d;
    logic [127:0]   rk_data_q,    rk_data_d;
    logic [1:0]     ready_q,      ready_d;
    logic           error_q,      error_d;

    logic           w_ack_data;
    logic           w_ack_tweak;
    logic           w_capture;

    // A new subkey is recognised by a change of the engine's round index;
    // indices beyond the last round are the engine's idle values.
    assign w_capture = (state_q == ST_COLLECT) &&
                       (i_ks_address <= c_LAST_ROUND) &&
                       (i_ks_address != prev_addr_q);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        bank_d       = bank_q;
        ks_key_d     = ks_key_q;
        prev_addr_d  = prev_addr_q;
        count_d      = count_q;
        timeout_d    = timeout_q;
        seen_low_d   = seen_low_q;
        rk_we_d      = 1'b0;
        rk_addr_d    = rk_addr_q;
        rk_data_d    = rk_data_q;
        ready_d      = ready_q;
        error_d      = error_q;
        w_ack_data   = 1'b0;
        w_ack_tweak  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Round-robin: on a tie, the bank not granted last time wins.
                if (i_req_data && (!i_req_tweak || last_grant_q)) begin
                    w_ack_data   = 1'b1;
                    ks_key_d     = i_key_data;
                    ready_d[0]   = 1'b0;
                    error_d      = 1'b0;
                    bank_d       = 1'b0;
                    last_grant_d = 1'b0;
                    state_d      = ST_START;
                end else if (i_req_tweak) begin
                    w_ack_tweak  = 1'b1;
                    ks_key_d     = i_key_tweak;
                    ready_d[1]   = 1'b0;
                    error_d      = 1'b0;
                    bank_d       = 1'b1;
                    last_grant_d = 1'b1;
                    state_d      = ST_START;
                end
            end

            ST_START: begin
                prev_addr_d = c_ADDR_NONE;
                count_d     = 6'd0;
                timeout_d   = 10'd0;
                seen_low_d  = 1'b0;
                state_d     = ST_COLLECT;
            end

            ST_COLLECT: begin
                timeout_d = timeout_q + 10'd1;
                if (!i_ks_subkey_valid) begin
                    seen_low_d = 1'b1;
                end
                if (w_capture) begin
                    rk_we_d     = 1'b1;
                    rk_addr_d   = {bank_q, i_ks_address};
                    rk_data_d   = i_ks_subkey;
                    prev_addr_d = i_ks_address;
                    if (count_q != c_NUM_SUBKEYS) begin
                        count_d = count_q + 6'd1;
                    end
                end
                // Valid is a level held from the previous run until the
                // engine sees begin, so only trust it after it was seen low.
                if (i_ks_subkey_valid && seen_low_q) begin
                    state_d = ST_DONE;
                end else if (timeout_d == c_TIMEOUT) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            ST_DONE: begin
                // The capture in the final COLLECT cycle is already counted.
                if (count_q == c_NUM_SUBKEYS) begin
                    ready_d[bank_q] = 1'b1;
                end else begin
                    error_d = 1'b1;
                end
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            bank_q       <= 1'b0;
            ks_key_q     <= '0;
            prev_addr_q  <= c_ADDR_NONE;
            count_q      <= 6'd0;
            timeout_q    <= 10'd0;
            seen_low_q   <= 1'b0;
            rk_we_q      <= 1'b0;
            rk_addr_q    <= 7'd0;
            rk_data_q    <= '0;
            ready_q      <= 2'b00;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            bank_q       <= bank_d;
            ks_key_q     <= ks_key_d;
            prev_addr_q  <= prev_addr_d;
            count_q      <= count_d;
            timeout_q    <= timeout_d;
            seen_low_q   <= seen_low_d;
            rk_we_q      <= rk_we_d;
            rk_addr_q    <= rk_addr_d;
            rk_data_q    <= rk_data_d;
            ready_q      <= ready_d;
            error_q      <= error_d;
        end
    end

    assign o_ack_data        = w_ack_data;
    assign o_ack_tweak       = w_ack_tweak;
    assign o_ks_begin        = (state_q == ST_START);
    assign o_ks_key          = ks_key_q;
    assign o_rk_we           = rk_we_q;
    assign o_rk_addr         = rk_addr_q;
    assign o_rk_data         = rk_data_q;
    assign o_data_key_ready  = ready_q[0];
    assign o_tweak_key_ready = ready_q[1];
    assign o_busy            = (state_q != ST_IDLE);
    assign o_error           = error_q;

endmodule
`default_nettype wire

// File: tb/tb_serpent_key_sched_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_serpent_key_sched_ctrl
// Purpose  : Directed bench for serpent_key_sched_ctrl with a behavioural
//            key-schedule engine (normal, never-valid and short modes).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serpent_key_sched_ctrl;

    logic         clk;
    logic         rstn;
    logic         req_data, req_tweak;
    logic [255:0] key_data, key_tweak;
    logic         ack_data, ack_tweak;
    logic         ks_begin;
    logic [255:0] ks_key;
    logic [127:0] ks_subkey;
    logic [5:0]   ks_address;
    logic         ks_valid;
    logic         rk_we;
    logic [6:0]   rk_addr;
    logic [127:0] rk_data;
    logic         rdy_data, rdy_tweak, busy, err;

    int n_checks = 0;
    int n_fail   = 0;

    serpent_key_sched_ctrl #(.KS_TIMEOUT(511)) u_dut (
        .i_clk             (clk),
        .i_rstn            (rstn),
        .i_req_data        (req_data),
        .i_key_data        (key_data),
        .o_ack_data        (ack_data),
        .i_req_tweak       (req_tweak),
        .i_key_tweak       (key_tweak),
        .o_ack_tweak       (ack_tweak),
        .o_ks_begin        (ks_begin),
        .o_ks_key          (ks_key),
        .i_ks_subkey       (ks_subkey),
        .i_ks_address      (ks_address),
        .i_ks_subkey_valid (ks_valid),
        .o_rk_we           (rk_we),
        .o_rk_addr         (rk_addr),
        .o_rk_data         (rk_data),
        .o_data_key_ready  (rdy_data),
        .o_tweak_key_ready (rdy_tweak),
        .o_busy            (busy),
        .o_error           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Subkey function of the behavioural engine.
    function automatic logic [127:0] sk(input logic [255:0] k, input logic [5:0] r);
        return {r, k[121:0]} ^ k[255:128] ^ {122'd0, r};
    endfunction

    // ---------------- behavioural engine ----------------
    // mode 0: rounds 0..32 then valid; 1: never steps, never valid;
    // 2: rounds 0..19 then valid (short run).
    logic [1:0]   eng_mode;
    logic [255:0] eng_key;
    logic [5:0]   eng_addr;
    logic         eng_run;
    logic         eng_valid;
    logic [5:0]   eng_last;

    assign eng_last   = (eng_mode == 2'd2) ? 6'd19 : 6'd32;
    assign ks_subkey  = sk(eng_key, eng_addr);
    assign ks_address = eng_addr;
    assign ks_valid   = eng_valid;

    always @(posedge clk) begin
        if (!rstn) begin
            eng_key   <= '0;
            eng_addr  <= 6'h3F;
            eng_run   <= 1'b0;
            eng_valid <= 1'b0;
        end else if (ks_begin) begin
            eng_key   <= ks_key;
            eng_valid <= 1'b0;
            if (eng_mode == 2'd1) begin
                eng_addr <= 6'h3F;
                eng_run  <= 1'b0;
            end else begin
                eng_addr <= 6'd0;
                eng_run  <= 1'b1;
            end
        end else if (eng_run) begin
            if (eng_addr == eng_last) begin
                eng_valid <= 1'b1;
                eng_run   <= 1'b0;
            end else begin
                eng_addr <= eng_addr + 6'd1;
            end
        end
    end

    // ---------------- monitors ----------------
    logic [6:0]   wa[$];
    logic [127:0] wd[$];
    bit           grants[$];
    logic         ack_prev = 1'b0;

    always @(negedge clk) begin
        if (rstn) begin
            if (rk_we) begin
                wa.push_back(rk_addr);
                wd.push_back(rk_data);
            end
            if (ack_data)  grants.push_back(1'b0);
            if (ack_tweak) grants.push_back(1'b1);
            if (ack_prev) check_eq("begin_after_ack", 256'(ks_begin), 256'(1'b1));
            ack_prev <= ack_data | ack_tweak;
        end else begin
            ack_prev <= 1'b0;
        end
    end

    // ---------------- helpers ----------------
    // Raise a request, wait for its ack, optionally drop it after the edge.
    task automatic drive_req(input bit bank, input logic [255:0] key, input bit drop);
        bit got = 1'b0;
        @(negedge clk);
        if (bank) begin req_tweak = 1'b1; key_tweak = key; end
        else      begin req_data  = 1'b1; key_data  = key; end
        #1;
        for (int i = 0; i < 3000 && !got; i++) begin
            if ((bank && ack_tweak) || (!bank && ack_data)) begin
                got = 1'b1;
                @(posedge clk);
                #1;
                if (drop) begin
                    if (bank) req_tweak = 1'b0; else req_data = 1'b0;
                end
            end else begin
                @(negedge clk);
                #1;
            end
        end
        if (!got) check_eq(bank ? "ack_tweak_wait" : "ack_data_wait", 256'(0), 256'(1));
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int i = 0; i < 3000 && !idle; i++) begin
            @(negedge clk);
            if (!busy) idle = 1'b1;
        end
        if (!idle) check_eq("idle_wait", 256'(0), 256'(1));
    endtask

    task automatic check_run(input bit bank, input logic [255:0] key, input int offs, input int n);
        for (int i = 0; i < n; i++) begin
            check_eq("wr_addr", 256'(wa[offs+i]), 256'({bank, 6'(i)}));
            check_eq("wr_data", 256'(wd[offs+i]), 256'(sk(key, 6'(i))));
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check_eq("rst_outs", 256'({ack_data, ack_tweak, ks_begin, rk_we, rk_addr,
                                   rdy_data, rdy_tweak, busy, err}), 256'(0));
        check_eq("rst_rk_data", 256'(rk_data), 256'(0));
        check_eq("rst_ks_key", ks_key, 256'(0));
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    localparam logic [255:0] c_KEY_D  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] c_KEY_T  = 256'hf0e1d2c3b4a5968778695a4b3c2d1e0ffedcba98765432100123456789abcdef;
    localparam logic [255:0] c_KEY_D2 = 256'h5555aaaa3333cccc0f0f0f0f12345678deadbeefcafef00d0badc0de87654321;
    localparam logic [255:0] c_KEY_T2 = 256'h1111222233334444555566667777888899990000aaaabbbbccccddddeeeeffff;

    initial begin
        int n;
        rstn = 1'b0; req_data = 1'b0; req_tweak = 1'b0;
        key_data = '0; key_tweak = '0; eng_mode = 2'd0;
        #1;
        check_eq("rst_outs", 256'({ack_data, ack_tweak, ks_begin, rk_we, rk_addr,
                                   rdy_data, rdy_tweak, busy, err}), 256'(0));
        check_eq("rst_ks_key", ks_key, 256'(0));
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        // 1: data-only load
        wa.delete(); wd.delete();
        drive_req(1'b0, c_KEY_D, 1'b1);
        check_eq("ks_key_latched", ks_key, c_KEY_D);
        check_eq("busy_after_ack", 256'(busy), 256'(1));
        wait_idle();
        check_eq("t1_nwr", 256'(wa.size()), 256'(33));
        check_run(1'b0, c_KEY_D, 0, 33);
        check_eq("t1_rdy_data", 256'(rdy_data), 256'(1));
        check_eq("t1_rdy_tweak", 256'(rdy_tweak), 256'(0));
        check_eq("t1_err", 256'(err), 256'(0));

        // 2: simultaneous requests after reset, data wins the tie
        apply_reset();
        wa.delete(); wd.delete(); grants.delete();
        fork
            drive_req(1'b0, c_KEY_D, 1'b1);
            drive_req(1'b1, c_KEY_T, 1'b1);
        join
        wait_idle();
        check_eq("t2_ngrant", 256'(grants.size()), 256'(2));
        check_eq("t2_grant0", 256'(grants[0]), 256'(0));
        check_eq("t2_grant1", 256'(grants[1]), 256'(1));
        check_eq("t2_nwr", 256'(wa.size()), 256'(66));
        check_run(1'b0, c_KEY_D, 0, 33);
        check_run(1'b1, c_KEY_T, 33, 33);
        check_eq("t2_rdy", 256'({rdy_data, rdy_tweak}), 256'(2'b11));

        // 3: both held for four runs, grants alternate
        grants.delete(); wa.delete(); wd.delete();
        fork
            begin
                drive_req(1'b0, c_KEY_D,  1'b0);
                drive_req(1'b0, c_KEY_D2, 1'b1);
            end
            begin
                drive_req(1'b1, c_KEY_T,  1'b0);
                drive_req(1'b1, c_KEY_T2, 1'b1);
            end
        join
        wait_idle();
        check_eq("t3_ngrant", 256'(grants.size()), 256'(4));
        for (int i = 0; i < 4; i++)
            check_eq("t3_grant_order", 256'(grants[i]), 256'(i % 2));
        check_eq("t3_nwr", 256'(wa.size()), 256'(132));
        check_run(1'b1, c_KEY_T2, 99, 33);
        check_eq("t3_rdy", 256'({rdy_data, rdy_tweak}), 256'(2'b11));

        // 4: engine never raises valid -> timeout after 511 COLLECT cycles
        eng_mode = 2'd1;
        wa.delete(); wd.delete();
        drive_req(1'b0, c_KEY_D, 1'b1);
        check_eq("t4_rdy_drop", 256'(rdy_data), 256'(0));
        n = 0;
        while (!err && n < 1000) begin
            @(negedge clk);
            n++;
        end
        // START at the first negedge, 511 COLLECT cycles, error seen next.
        check_eq("t4_timeout_cycles", 256'(n), 256'(513));
        check_eq("t4_busy", 256'(busy), 256'(0));
        check_eq("t4_rdy_data", 256'(rdy_data), 256'(0));
        check_eq("t4_rdy_tweak", 256'(rdy_tweak), 256'(1));

        // 5: short run (20 subkeys) on tweak bank; ack clears error
        eng_mode = 2'd2;
        wa.delete(); wd.delete();
        drive_req(1'b1, c_KEY_T, 1'b1);
        check_eq("t5_err_cleared", 256'(err), 256'(0));
        check_eq("t5_rdy_drop", 256'(rdy_tweak), 256'(0));
        wait_idle();
        check_eq("t5_err", 256'(err), 256'(1));
        check_eq("t5_rdy", 256'({rdy_data, rdy_tweak}), 256'(0));
        check_eq("t5_nwr", 256'(wa.size()), 256'(20));
        check_run(1'b1, c_KEY_T, 0, 20);

        // 6: reset mid-COLLECT, then a clean reload
        eng_mode = 2'd0;
        wa.delete(); wd.delete();
        drive_req(1'b0, c_KEY_D2, 1'b1);
        n = 0;
        while (wa.size() < 10 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("t6_reached_10wr", 256'(wa.size() >= 10), 256'(1));
        apply_reset();
        @(negedge clk);
        check_eq("t6_idle_after_rst", 256'({busy, rk_we, rdy_data, rdy_tweak, err}), 256'(0));
        wa.delete(); wd.delete();
        drive_req(1'b0, c_KEY_D, 1'b1);
        wait_idle();
        check_eq("t6_nwr", 256'(wa.size()), 256'(33));
        check_run(1'b0, c_KEY_D, 0, 33);
        check_eq("t6_rdy", 256'({rdy_data, rdy_tweak, err}), 256'(3'b100));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
